// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the conv layer output path.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WAIT,
        EMIT
    } conv_act_state_t;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    // Enough headroom to add v_tiles signed words without overflow.
    function automatic int acc_width(input int data_w, input int v_tiles);
        return data_w + $clog2(v_tiles) + 1;
    endfunction

endpackage

// File: rtl/conv_act_requant.sv
// Combines one channel's vertical-tile partial sums, then applies ReLU,
// the requantisation shift and unsigned saturation.
module conv_act_requant
    import conv_pkg::*;
#(
    parameter int v_tiles              = 1,
    parameter int datatype_size        = 8,
    parameter int output_datatype_size = 8,
    parameter int shift                = 0
) (
    input  logic [datatype_size-1:0]        words [v_tiles],
    output logic [output_datatype_size-1:0] result
);

    localparam int acc_w = acc_width(datatype_size, v_tiles);
    // One extra bit over the wider of accumulator and output keeps the
    // saturation limit representable as a positive signed value.
    localparam int cmp_w = ((acc_w > output_datatype_size) ? acc_w : output_datatype_size) + 1;

    localparam logic signed [cmp_w-1:0] max_val =
        {{(cmp_w - output_datatype_size){1'b0}}, {output_datatype_size{1'b1}}};

    logic signed [cmp_w-1:0] sum;
    logic signed [cmp_w-1:0] shifted;

    always_comb begin
        sum = '0;
        for (int i = 0; i < v_tiles; i++) begin
            sum = sum + {{(cmp_w - datatype_size){words[i][datatype_size-1]}}, words[i]};
        end
        shifted = sum >>> shift;
        result  = '0;
        if (sum > 0) begin
            result = (shifted > max_val) ? {output_datatype_size{1'b1}}
                                         : shifted[output_datatype_size-1:0];
        end
    end

endmodule

// File: rtl/conv_act_stream.sv
// Reads every output channel of a finished pixel from the CIM buffers,
// requantises it and writes all channels to the next layer in one strobe.
module conv_act_stream
    import conv_pkg::*;
#(
    parameter int input_size           = 45,
    parameter int output_size          = 10,
    parameter int xbar_size            = 256,
    parameter int datatype_size        = 8,
    parameter int output_datatype_size = 8,
    parameter int shift                = 0,
    localparam int v_cim_tiles         = ceil_div(input_size, xbar_size),
    localparam int h_cim_tiles         = ceil_div(output_size, xbar_size)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_start,
    input  logic                            i_cim_busy,
    input  logic [datatype_size-1:0]        i_data [v_cim_tiles][h_cim_tiles],
    output logic [$clog2(xbar_size)-1:0]    o_cim_rd_addr,
    input  logic                            i_next_busy,
    output logic [output_size-1:0]          o_ibuf_we,
    output logic [output_datatype_size-1:0] o_ibuf_wr_data [output_size],
    output logic                            o_busy
);

    localparam int ch_w   = (output_size > 1) ? $clog2(output_size) : 1;
    localparam int h_w    = (h_cim_tiles > 1) ? $clog2(h_cim_tiles) : 1;
    localparam int addr_w = $clog2(xbar_size);
    localparam logic [ch_w-1:0] last_ch = ch_w'(output_size - 1);

    conv_act_state_t state;

    logic [ch_w-1:0]                 rd_ch;
    logic                            issuing;
    logic [ch_w-1:0]                 cap_ch;
    logic                            cap_valid;
    logic [h_w-1:0]                  cap_tile;
    logic [datatype_size-1:0]        cap_words [v_cim_tiles];
    logic [output_datatype_size-1:0] cap_result;
    logic [output_datatype_size-1:0] results [output_size];

    // The buffer answers one cycle after the address, so the capture side
    // trails the address side by one channel.
    assign cap_tile = h_w'(int'(cap_ch) / xbar_size);

    always_comb begin
        for (int v = 0; v < v_cim_tiles; v++) begin
            cap_words[v] = i_data[v][cap_tile];
        end
    end

    conv_act_requant #(
        .v_tiles              (v_cim_tiles),
        .datatype_size        (datatype_size),
        .output_datatype_size (output_datatype_size),
        .shift                (shift)
    ) u_requant (
        .words  (cap_words),
        .result (cap_result)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            o_busy        <= 1'b0;
            o_cim_rd_addr <= '0;
            o_ibuf_we     <= '0;
            rd_ch         <= '0;
            issuing       <= 1'b0;
            cap_ch        <= '0;
            cap_valid     <= 1'b0;
            for (int c = 0; c < output_size; c++) begin
                o_ibuf_wr_data[c] <= '0;
                results[c]        <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    o_ibuf_we <= '0;
                    if (i_start && !i_cim_busy) begin
                        state         <= READ;
                        o_busy        <= 1'b1;
                        rd_ch         <= '0;
                        o_cim_rd_addr <= '0;
                        issuing       <= 1'b1;
                        cap_valid     <= 1'b0;
                    end
                end

                READ: begin
                    cap_valid <= issuing;
                    cap_ch    <= rd_ch;
                    if (issuing) begin
                        if (rd_ch == last_ch) begin
                            issuing <= 1'b0;
                        end else begin
                            rd_ch         <= rd_ch + 1'b1;
                            o_cim_rd_addr <= addr_w'((int'(rd_ch) + 1) % xbar_size);
                        end
                    end
                    if (cap_valid) begin
                        results[cap_ch] <= cap_result;
                        if (cap_ch == last_ch) begin
                            state <= WAIT;
                        end
                    end
                end

                WAIT: begin
                    if (!i_next_busy) begin
                        o_ibuf_we <= '1;
                        for (int c = 0; c < output_size; c++) begin
                            o_ibuf_wr_data[c] <= results[c];
                        end
                        state <= EMIT;
                    end
                end

                EMIT: begin
                    o_ibuf_we <= '0;
                    o_busy    <= 1'b0;
                    state     <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_act_stream.sv
// Self-checking bench for conv_act_stream: two instances (8-bit and 6-bit
// activations) share one modelled CIM buffer and are checked against a reference.
module tb_conv_act_stream;

    localparam int IN_SIZE  = 6;
    localparam int OUT_SIZE = 6;
    localparam int XBAR     = 4;
    localparam int SHIFT    = 1;

    typedef struct {
        byte w0;
        byte w1;
        int  exp8;
        int  exp6;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic i_start;
    logic i_cim_busy;
    logic i_next_busy;
    logic [7:0] cim_data [2][2];
    logic [1:0] addr8;
    logic [1:0] addr6;
    logic [5:0] we8;
    logic [5:0] we6;
    logic [7:0] wr8 [OUT_SIZE];
    logic [5:0] wr6 [OUT_SIZE];
    logic busy8;
    logic busy6;

    byte mem [2][2][XBAR];
    int  snap8 [OUT_SIZE];
    int  snap6 [OUT_SIZE];
    int  tests  = 0;
    int  failed = 0;

    always #5 clk = ~clk;

    conv_act_stream #(
        .input_size(IN_SIZE), .output_size(OUT_SIZE), .xbar_size(XBAR),
        .datatype_size(8), .output_datatype_size(8), .shift(SHIFT)
    ) dut8 (
        .clk(clk), .rst(rst), .i_start(i_start), .i_cim_busy(i_cim_busy),
        .i_data(cim_data), .o_cim_rd_addr(addr8), .i_next_busy(i_next_busy),
        .o_ibuf_we(we8), .o_ibuf_wr_data(wr8), .o_busy(busy8)
    );

    conv_act_stream #(
        .input_size(IN_SIZE), .output_size(OUT_SIZE), .xbar_size(XBAR),
        .datatype_size(8), .output_datatype_size(6), .shift(SHIFT)
    ) dut6 (
        .clk(clk), .rst(rst), .i_start(i_start), .i_cim_busy(i_cim_busy),
        .i_data(cim_data), .o_cim_rd_addr(addr6), .i_next_busy(i_next_busy),
        .o_ibuf_we(we6), .o_ibuf_wr_data(wr6), .o_busy(busy6)
    );

    // CIM output buffers: synchronous read, one cycle after the address.
    always @(posedge clk) begin
        for (int v = 0; v < 2; v++) begin
            for (int h = 0; h < 2; h++) begin
                cim_data[v][h] <= mem[v][h][addr8];
            end
        end
    end

    function automatic int ref_act(input int ch, input int out_w);
        int sum;
        int scaled;
        int limit;
        sum = int'(mem[0][ch / XBAR][ch % XBAR]) + int'(mem[1][ch / XBAR][ch % XBAR]);
        if (sum <= 0) return 0;
        scaled = sum / (1 << SHIFT);
        limit  = (1 << out_w) - 1;
        return (scaled > limit) ? limit : scaled;
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic fill_random();
        for (int v = 0; v < 2; v++)
            for (int h = 0; h < 2; h++)
                for (int a = 0; a < XBAR; a++)
                    mem[v][h][a] = byte'($urandom);
    endtask

    task automatic take_snapshot();
        for (int c = 0; c < OUT_SIZE; c++) begin
            snap8[c] = int'(wr8[c]);
            snap6[c] = int'(wr6[c]);
        end
    endtask

    task automatic checkOutput(input string tag);
        for (int c = 0; c < OUT_SIZE; c++) begin
            check($sformatf("%s_d8[%0d]", tag, c), snap8[c], ref_act(c, 8));
            check($sformatf("%s_d6[%0d]", tag, c), snap6[c], ref_act(c, 6));
        end
    endtask

    // Called at a negedge; start is accepted on the next posedge (edge 0).
    task automatic applyStimulus(input string tag, input int stall);
        int early;
        i_next_busy = (stall > 0);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        check({tag, "_busy_on"}, int'(busy8 & busy6), 1);
        early = 0;
        for (int k = 1; k <= OUT_SIZE + 1 + stall; k++) begin
            @(negedge clk);
            if (we8 != 6'd0 || we6 != 6'd0 || !busy8) early++;
        end
        check({tag, "_no_early_strobe"}, early, 0);
        i_next_busy = 1'b0;
        @(negedge clk);
        check({tag, "_we8"}, int'(we8), 63);
        check({tag, "_we6"}, int'(we6), 63);
        take_snapshot();
        checkOutput(tag);
        @(negedge clk);
        check({tag, "_we_clear"}, int'(we8 | we6), 0);
        check({tag, "_busy_off"}, int'(busy8 | busy6), 0);
    endtask

    initial begin
        vec_t vecs [10];
        int   strobes;
        int   nonzero;

        vecs = '{
            '{40, 30, 35, 35},
            '{-100, 20, 0, 0},
            '{127, 127, 127, 63},
            '{-128, -128, 0, 0},
            '{1, 0, 0, 0},
            '{3, 0, 1, 1},
            '{-1, 2, 0, 0},
            '{100, 100, 100, 63},
            '{64, 62, 63, 63},
            '{64, 64, 64, 63}
        };

        rst = 1'b1;
        i_start = 1'b0;
        i_cim_busy = 1'b0;
        i_next_busy = 1'b0;
        for (int v = 0; v < 2; v++)
            for (int h = 0; h < 2; h++)
                for (int a = 0; a < XBAR; a++)
                    mem[v][h][a] = 8'sd0;

        repeat (2) @(negedge clk);
        check("rst_busy", int'(busy8 | busy6), 0);
        check("rst_we", int'(we8 | we6), 0);
        check("rst_addr", int'(addr8), 0);
        check("rst_data", int'(wr8[5]) + int'(wr6[0]), 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_busy", int'(busy8), 0);

        // Start refused while the CIM is still computing.
        i_cim_busy = 1'b1;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        strobes = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (busy8 || busy6 || we8 != 6'd0) strobes++;
        end
        check("cim_busy_ignored", strobes, 0);
        i_cim_busy = 1'b0;

        // Table vectors on channel 5 (h tile 1, column 1), run back-to-back.
        for (int i = 0; i < 10; i++) begin
            fill_random();
            mem[0][1][1] = vecs[i].w0;
            mem[1][1][1] = vecs[i].w1;
            applyStimulus($sformatf("vec%0d", i), 0);
            check($sformatf("vec%0d_ch5_d8", i), snap8[5], vecs[i].exp8);
            check($sformatf("vec%0d_ch5_d6", i), snap6[5], vecs[i].exp6);
        end

        fill_random();
        applyStimulus("backpressure", 10);

        // A second start during READ must not produce a second pixel.
        fill_random();
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (3) @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        strobes = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (we8 == 6'h3f) begin
                strobes++;
                take_snapshot();
            end
        end
        check("restart_single_emit", strobes, 1);
        checkOutput("restart");

        for (int n = 0; n < 15; n++) begin
            fill_random();
            applyStimulus($sformatf("rnd%0d", n), int'($urandom_range(0, 3)));
        end

        // Reset while address 3 is on the bus.
        fill_random();
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_read_addr", int'(addr8), 3);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", int'(busy8 | busy6), 0);
        check("mid_rst_addr", int'(addr8), 0);
        check("mid_rst_we", int'(we8 | we6), 0);
        nonzero = 0;
        for (int c = 0; c < OUT_SIZE; c++) begin
            if (wr8[c] != 8'd0 || wr6[c] != 6'd0) nonzero++;
        end
        check("mid_rst_data", nonzero, 0);
        @(negedge clk);
        rst = 1'b0;
        strobes = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (we8 != 6'd0 || we6 != 6'd0 || busy8) strobes++;
        end
        check("lost_pixel_quiet", strobes, 0);
        fill_random();
        applyStimulus("post_rst", 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
